serial_adder: RTL

- Parametrised, bit-serial successor to the single-bit combinational full adder.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, using a single full-adder cell and a registered carry.
- Start/busy/done handshake so a datapath controller can issue additions and collect registered results.
- Trades latency for area in narrow-area arithmetic paths.

---
 rtl/serial_adder.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB first,
// start/busy/done handshake. Define SERIAL_ADDER_OVF_EN to add a signed-overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry, s_bit, c_nxt, load, last;

  // Full-adder cell on the current LSBs; result bits enter at the MSB end.
  always_comb begin
    load    = start && (state != RUN);
    last    = (state == RUN) && (cnt == CNT_W'(WIDTH-1));
    s_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    c_nxt   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    res_nxt = (res_sr >> 1) | (WIDTH'(s_bit) << (WIDTH-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done come straight from flops so they cannot glitch on state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      carry  <= c_nxt;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= res_nxt;
        cout <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
        // carry holds the carry into the MSB on the final bit
        ovf  <= carry ^ c_nxt;
`endif
      end
    end
  end

endmodule
